// File: rtl/ff_bank_pkg.sv
// Shared encodings for the universal flip-flop bank: mode select and JK/SR input pairs.
package ff_bank_pkg;
    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_DFF   = 3'd1;
    localparam logic [2:0] MODE_TFF   = 3'd2;
    localparam logic [2:0] MODE_JK    = 3'd3;
    localparam logic [2:0] MODE_SR    = 3'd4;
    localparam logic [2:0] MODE_UP    = 3'd5;
    localparam logic [2:0] MODE_DOWN  = 3'd6;
    localparam logic [2:0] MODE_MLOAD = 3'd7;

    // {j,k} pairs
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // {s,r} pairs; SR_ILL holds the bit and raises err
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_CLR  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_ILL  = 2'b11;
endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: D/T/JK/SR/masked-load flop, or a T stage of the counter chain.
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       t_chain,
    output logic       q
);
    logic d;

    always_comb begin
        d = q;
        case (mode)
            MODE_HOLD: d = q;
            MODE_DFF:  d = a;
            MODE_TFF:  d = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    JK_HOLD: d = q;
                    JK_CLR:  d = 1'b0;
                    JK_SET:  d = 1'b1;
                    JK_TOG:  d = ~q;
                    default: d = q;
                endcase
            end
            MODE_SR: begin
                case ({a, b})
                    SR_CLR:  d = 1'b0;
                    SR_SET:  d = 1'b1;
                    default: d = q;
                endcase
            end
            MODE_UP, MODE_DOWN: d = q ^ t_chain;
            MODE_MLOAD: d = b ? a : q;
            default: d = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RST_BIT;
        else if (en) q <= d;
    end
endmodule

// File: rtl/ff_bank_univ.sv
// Bank of WIDTH universal flip-flops with shared mode, counter carry chain, tc and err flags.
module ff_bank_univ
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             err
);
    logic [WIDTH-1:0] t_up, t_dn, t_chain;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // bit i toggles once every lower bit is 1 (up) or 0 (down)
            if (i == 0) begin : g_lsb
                assign t_up[i] = 1'b1;
                assign t_dn[i] = 1'b1;
            end else begin : g_upper
                assign t_up[i] = &q[i-1:0];
                assign t_dn[i] = ~|q[i-1:0];
            end

            ff_cell #(.RST_BIT(RST_VAL[i])) u_cell (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .mode    (mode),
                .a       (a[i]),
                .b       (b[i]),
                .t_chain (t_chain[i]),
                .q       (q[i])
            );
        end
    endgenerate

    assign t_chain = (mode == MODE_DOWN) ? t_dn : t_up;
    assign qn      = ~q;
    assign tc      = ~rst & en & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~|q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= en & (mode == MODE_SR) & (|(a & b));
    end
endmodule

// File: tb/tb_ff_bank_univ.sv
// Scoreboard bench for ff_bank_univ at WIDTH=4, RST_VAL=0101.
module tb_ff_bank_univ;
    import ff_bank_pkg::*;

    localparam int         W   = 4;
    localparam logic [3:0] RV  = 4'b0101;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = MODE_HOLD;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] q, qn;
    logic         tc, err;

    ff_bank_univ #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q), .qn(qn), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         err;
        logic         tc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e;
    logic [W-1:0] m_q;
    logic         obs_tc;
    int           n_pass = 0, n_total = 0;

    function automatic logic [W-1:0] model_next(logic [W-1:0] cq, logic cen, logic [2:0] cm,
                                                 logic [W-1:0] ca, logic [W-1:0] cb);
        logic [W-1:0] r;
        r = cq;
        if (cen) begin
            case (cm)
                MODE_DFF:   r = ca;
                MODE_TFF:   r = cq ^ ca;
                MODE_JK:    r = (cq & ~cb) | (ca & ~cq) | (cq & ~(ca & cb) & ~cb) | (ca & ~cb);
                MODE_SR:    r = (cq | (ca & ~cb)) & ~(cb & ~ca);
                MODE_UP:    r = cq + 1'b1;
                MODE_DOWN:  r = cq - 1'b1;
                MODE_MLOAD: r = (cq & ~cb) | (ca & cb);
                default:    r = cq;
            endcase
        end
        return r;
    endfunction

    // Drive one edge's inputs, record pre-edge tc, push the expectation, then clock.
    task automatic drive(input logic ien, input logic [2:0] im, input logic [W-1:0] ia,
                         input logic [W-1:0] ib);
        exp_t x;
        en = ien; mode = im; a = ia; b = ib;
        #1;
        obs_tc = tc;
        x.tc  = ien & (((im == MODE_UP) & (m_q == '1)) | ((im == MODE_DOWN) & (m_q == '0)));
        x.q   = model_next(m_q, ien, im, ia, ib);
        x.err = ien & (im == MODE_SR) & (|(ia & ib));
        m_q   = x.q;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        m_q = RV;
        drive(1'b1, MODE_DFF, 4'b1111, 4'b0000);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q) $display("FAIL rst_preload: q=%b want %b", q, e.q); else n_pass++;
        #3;
        en = 1'b1; mode = MODE_UP;
        rst = 1'b1;
        #1;
        n_total++;
        if (q !== RV) $display("FAIL rst_async_q: q=%b want %b", q, RV); else n_pass++;
        n_total++;
        if (qn !== ~RV) $display("FAIL rst_async_qn: qn=%b want %b", qn, ~RV); else n_pass++;
        n_total++;
        if (err !== 1'b0 || tc !== 1'b0)
            $display("FAIL rst_flags: err=%b tc=%b want 0 0", err, tc); else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (q !== RV) $display("FAIL rst_held: q=%b want %b", q, RV); else n_pass++;
        rst = 1'b0;
        m_q = RV;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, MODE_HOLD, 4'b1111, 4'b1111);
            e = sbq.pop_front();
            n_total++;
            if (q !== e.q || q !== RV) $display("FAIL hold_%0d: q=%b want %b", k, q, RV); else n_pass++;
        end
    endtask

    task automatic test_up_wrap;
        logic [W-1:0] seq [4];
        seq = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
        drive(1'b1, MODE_DFF, 4'b1101, 4'b0000);
        e = sbq.pop_front();
        n_total++;
        if (q !== 4'b1101) $display("FAIL up_load: q=%b want 1101", q); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, MODE_UP, $urandom, $urandom);
            e = sbq.pop_front();
            n_total++;
            if (obs_tc !== e.tc) $display("FAIL up_tc_%0d: tc=%b want %b", k, obs_tc, e.tc); else n_pass++;
            n_total++;
            if (q !== e.q || q !== seq[k] || qn !== ~seq[k])
                $display("FAIL up_q_%0d: q=%b qn=%b want %b", k, q, qn, seq[k]); else n_pass++;
        end
    endtask

    task automatic test_down_gap;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, MODE_DOWN, 4'b0000, 4'b0000);
            e = sbq.pop_front();
            n_total++;
            if (q !== e.q) $display("FAIL down_q_%0d: q=%b want %b", k, q, e.q); else n_pass++;
            #1;
            n_total++;
            if (tc !== (k == 0)) $display("FAIL down_tc_%0d: tc=%b want %b", k, tc, k == 0); else n_pass++;
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, MODE_SR, 4'b1111, 4'b1111);
            e = sbq.pop_front();
            n_total++;
            if (q !== 4'b1111 || err !== 1'b0 || obs_tc !== 1'b0)
                $display("FAIL en_gap_%0d: q=%b err=%b tc=%b want 1111 0 0", k, q, err, obs_tc); else n_pass++;
        end
    endtask

    task automatic test_tff_jk;
        drive(1'b1, MODE_DFF, 4'b0000, 4'b1111);
        e = sbq.pop_front();
        drive(1'b1, MODE_TFF, 4'b1010, 4'b0101);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q || q !== 4'b1010) $display("FAIL tff: q=%b want 1010", q); else n_pass++;
        // bit3 set, bit2 toggles 0->1, bit1 clear, bit0 hold
        drive(1'b1, MODE_JK, 4'b1100, 4'b0110);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q || q !== 4'b1100) $display("FAIL jk: q=%b want 1100", q); else n_pass++;
        drive(1'b1, MODE_JK, 4'b1111, 4'b1111);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q) $display("FAIL jk_toggle: q=%b want %b", q, e.q); else n_pass++;
    endtask

    task automatic test_sr_illegal;
        drive(1'b1, MODE_DFF, 4'b0011, 4'b0000);
        e = sbq.pop_front();
        drive(1'b1, MODE_SR, 4'b1001, 4'b0101);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q || q !== 4'b1011) $display("FAIL sr_q: q=%b want 1011", q); else n_pass++;
        n_total++;
        if (err !== e.err || err !== 1'b1) $display("FAIL sr_err: err=%b want 1", err); else n_pass++;
        drive(1'b1, MODE_SR, 4'b0100, 4'b0001);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q || err !== 1'b0) $display("FAIL sr_next: q=%b err=%b want %b 0", q, err, e.q); else n_pass++;
    endtask

    task automatic test_mload_reset;
        logic [W-1:0] seq [2];
        seq = '{4'b0110, 4'b0111};
        drive(1'b1, MODE_DFF, 4'b1111, 4'b0000);
        e = sbq.pop_front();
        drive(1'b1, MODE_MLOAD, 4'b0000, 4'b0110);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q || q !== 4'b1001) $display("FAIL mload: q=%b want 1001", q); else n_pass++;
        drive(1'b1, MODE_UP, 4'b0000, 4'b0000);
        e = sbq.pop_front();
        n_total++;
        if (q !== e.q) $display("FAIL mid_up: q=%b want %b", q, e.q); else n_pass++;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        m_q = RV;
        n_total++;
        if (q !== RV) $display("FAIL mid_rst: q=%b want %b", q, RV); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, MODE_UP, 4'b0000, 4'b0000);
            e = sbq.pop_front();
            n_total++;
            if (q !== e.q || q !== seq[k]) $display("FAIL resume_%0d: q=%b want %b", k, q, seq[k]); else n_pass++;
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            drive(1'($urandom_range(0, 5) != 0), 3'($urandom), 4'($urandom), 4'($urandom));
            e = sbq.pop_front();
            n_total++;
            if (q !== e.q || qn !== ~e.q || err !== e.err || obs_tc !== e.tc)
                $display("FAIL rand_%0d: q=%b err=%b tc=%b want %b %b %b",
                         k, q, err, obs_tc, e.q, e.err, e.tc);
            else n_pass++;
        end
    endtask

    initial begin
        m_q = RV;
        test_reset();
        test_up_wrap();
        test_down_gap();
        test_tff_jk();
        test_sr_illegal();
        test_mload_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
